sar_controller: RTL and testbench

SAR_CONTROLLER -- requirements
Module: sar_controller

---
 rtl/sar_pkg.sv | 12 +
 rtl/sar_if.sv | 25 ++
 rtl/sar_controller.sv | 108 ++++++++++
 tb/tb_sar_controller.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared state encoding and default width for the SAR controller
package sar_pkg;

  localparam int SAR_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } sar_state_e;

endpackage

// File: rtl/sar_if.sv
// rtl/sar_if.sv - start/comparator/result bundle between SAR controller and its user
interface sar_if #(
  parameter int WIDTH = sar_pkg::SAR_WIDTH
);
  logic             start;
  logic             cmp_gt;
  logic             cmp_eq;
  logic             cmp_lt;
  logic [WIDTH-1:0] trial;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             exact;
  logic             err;

  modport master (
    output start, cmp_gt, cmp_eq, cmp_lt,
    input  trial, busy, done, result, exact, err
  );

  modport slave (
    input  start, cmp_gt, cmp_eq, cmp_lt,
    output trial, busy, done, result, exact, err
  );
endinterface

// File: rtl/sar_controller.sv
// rtl/sar_controller.sv - successive-approximation search, one bit per cycle, with
// early exit on an exact comparator match
module sar_controller
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  sar_if.slave bus
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  sar_state_e       state_q;
  logic [WIDTH-1:0] trial_q;
  logic [WIDTH-1:0] result_q;
  logic [IDX_W-1:0] idx_q;
  logic             busy_q;
  logic             done_q;
  logic             exact_q;
  logic             err_q;

  logic             code_ok;
  logic             take_gt;
  logic             take_eq;
  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] decided_d;
  logic [WIDTH-1:0] trial_d;

  // Anything but a clean one-hot code falls through to the "less than" path.
  always_comb begin
    code_ok   = 1'b0;
    case ({bus.cmp_gt, bus.cmp_eq, bus.cmp_lt})
      3'b100, 3'b010, 3'b001: code_ok = 1'b1;
      default:                code_ok = 1'b0;
    endcase
    take_gt   = code_ok & bus.cmp_gt;
    take_eq   = code_ok & bus.cmp_eq;
    bit_mask  = {{(WIDTH-1){1'b0}}, 1'b1} << idx_q;
    decided_d = take_gt ? trial_q : (trial_q & ~bit_mask);
    trial_d   = decided_d | (bit_mask >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      trial_q  <= '0;
      result_q <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      exact_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q <= S_CONVERT;
            trial_q <= {1'b1, {(WIDTH-1){1'b0}}};
            idx_q   <= IDX_W'(WIDTH-1);
            exact_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_CONVERT: begin
          if (!code_ok) begin
            err_q <= 1'b1;
          end
          if (take_eq) begin
            result_q <= trial_q;
            exact_q  <= 1'b1;
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else if (idx_q == '0) begin
            // trial keeps the final decided value so it matches result afterwards
            result_q <= decided_d;
            trial_q  <= decided_d;
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            trial_q <= trial_d;
            idx_q   <= idx_q - 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.trial  = trial_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.exact  = exact_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_sar_controller.sv
// tb/tb_sar_controller.sv - scoreboard bench for sar_controller with a modelled
// comparator around a hidden unknown value
module tb_sar_controller;
  import sar_pkg::*;

  typedef struct {
    logic [7:0] res;
    logic       exact;
    logic       err;
    int         cycles;
  } exp_t;

  logic clk;
  logic rst_n;

  sar_if #(.WIDTH(8)) bus ();

  sar_controller #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] unknown;
  logic       force_en;
  logic [7:0] force_trial;

  always_comb begin
    bus.cmp_gt = 1'b0;
    bus.cmp_eq = 1'b0;
    bus.cmp_lt = 1'b0;
    if (force_en && bus.trial == force_trial) begin
      bus.cmp_gt = 1'b1;
      bus.cmp_lt = 1'b1;
    end else begin
      bus.cmp_gt = unknown > bus.trial;
      bus.cmp_eq = unknown == bus.trial;
      bus.cmp_lt = unknown < bus.trial;
    end
  end

  int         checks = 0;
  int         errors = 0;
  exp_t       sb_q[$];
  logic [7:0] trial_log[$];
  int         busy_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Accumulator-style reference search: each bit is tried on top of the bits kept so far.
  function automatic exp_t model(input logic [7:0] unk, input bit frc, input logic [7:0] ft);
    exp_t       e;
    logic [7:0] acc;
    logic [7:0] t;
    int         k;
    acc = 8'h00;
    k = 0;
    e.res = 8'h00;
    e.exact = 1'b0;
    e.err = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      t = acc | (8'd1 << i);
      k++;
      if (frc && t == ft) begin
        e.err = 1'b1;
      end else if (unk == t) begin
        e.res = t;
        e.exact = 1'b1;
        break;
      end else if (unk > t) begin
        acc = t;
      end
    end
    if (!e.exact) e.res = acc;
    e.cycles = k + 1;
    return e;
  endfunction

  // Called at a negedge; leaves at a negedge one cycle after done.
  task automatic run_conv(input string tag, input logic [7:0] unk, input bit frc,
                          input logic [7:0] ft, input int restart_at);
    exp_t e;
    int   cyc;
    bit   got;
    sb_q.push_back(model(unk, frc, ft));
    unknown = unk;
    force_en = frc;
    force_trial = ft;
    trial_log.delete();
    busy_cnt = 0;
    bus.start = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (cyc < 40 && !got) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      bus.start = (cyc == restart_at);
      if (cyc == 1) check_eq({tag, "_err_cleared"}, bus.err, 1'b0);
      if (bus.busy) begin
        trial_log.push_back(bus.trial);
        busy_cnt++;
      end
      if (bus.done) got = 1'b1;
    end
    bus.start = 1'b0;
    if (!got) begin
      check_eq({tag, "_timeout"}, 32'd0, 32'd1);
      void'(sb_q.pop_front());
    end else begin
      e = sb_q.pop_front();
      check_eq({tag, "_result"}, bus.result, e.res);
      check_eq({tag, "_exact"}, bus.exact, e.exact);
      check_eq({tag, "_err"}, bus.err, e.err);
      check_eq({tag, "_latency"}, cyc, e.cycles);
      check_eq({tag, "_busy_in_done"}, bus.busy, 1'b0);
      @(negedge clk);
      check_eq({tag, "_done_one_cycle"}, bus.done, 1'b0);
      check_eq({tag, "_result_held"}, bus.result, e.res);
      check_eq({tag, "_err_held"}, bus.err, e.err);
    end
  endtask

  logic [7:0] exp_seq[8];
  bit         saw_done;

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    unknown = 8'h00;
    force_en = 1'b0;
    force_trial = 8'h00;
    exp_seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

    repeat (2) @(negedge clk);
    check_eq("rst_trial", bus.trial, 8'h00);
    check_eq("rst_result", bus.result, 8'h00);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_done", bus.done, 1'b0);
    check_eq("rst_exact", bus.exact, 1'b0);
    check_eq("rst_err", bus.err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    run_conv("a5", 8'hA5, 1'b0, 8'h00, 0);
    check_eq("a5_trial_count", trial_log.size(), 8);
    for (int i = 0; i < 8 && i < trial_log.size(); i++)
      check_eq($sformatf("a5_trial%0d", i), trial_log[i], exp_seq[i]);

    run_conv("x80", 8'h80, 1'b0, 8'h00, 0);
    check_eq("x80_busy_cycles", busy_cnt, 1);

    run_conv("x00", 8'h00, 1'b0, 8'h00, 0);
    check_eq("x00_trial_final", bus.trial, 8'h00);
    run_conv("xff", 8'hFF, 1'b0, 8'h00, 0);

    run_conv("force", 8'hA5, 1'b1, 8'hA0, 0);
    check_eq("force_bit5_cleared", bus.result[5], 1'b0);
    run_conv("after_force", 8'h3C, 1'b0, 8'h00, 0);

    run_conv("restart", 8'h5A, 1'b0, 8'h00, 3);
    repeat (3) @(negedge clk);
    check_eq("restart_result_hold", bus.result, 8'h5A);
    check_eq("idle_busy", bus.busy, 1'b0);

    unknown = 8'h5A;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("abort_busy_before", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_trial", bus.trial, 8'h00);
    check_eq("abort_result", bus.result, 8'h00);
    check_eq("abort_busy", bus.busy, 1'b0);
    check_eq("abort_done", bus.done, 1'b0);
    check_eq("abort_exact", bus.exact, 1'b0);
    check_eq("abort_err", bus.err, 1'b0);
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
      if (i == 3) rst_n = 1'b1;
    end
    check_eq("abort_no_done", saw_done, 1'b0);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_conv("post_reset", 8'h33, 1'b0, 8'h00, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
